// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and the bubble instruction.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/reg_if_id.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module reg_if_id #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               stall,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    // Prioritised update of the valid/instr/pc triple; pc is kept on flush and bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                valid <= 1'b1;
                instr <= load_instr;
                pc    <= load_pc;
            end else begin
                valid <= 1'b0;
                instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: req/ack handshake with instruction memory, parking buffer for
// stalled/halted responses, drain of abandoned requests after a flush, and
// pc_hold feedback so the PC advances only when a fetch retires.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_hold,
    input  logic               halt_sys,
    input  logic               id_stall,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc
);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [INSTR_W-1:0] buf_instr_q;
    logic [ADDR_W-1:0]  buf_pc_q;
    logic [ADDR_W-1:0]  drain_addr_q;
    logic               do_accept;
    logic               do_release;
    logic               ifid_load;
    logic [INSTR_W-1:0] ifid_load_instr;
    logic [ADDR_W-1:0]  ifid_load_pc;

    assign do_accept  = (state_q == REQ) && imem_ack && !id_stall && !flush && !halt_sys;
    assign do_release = (state_q == HOLD) && !id_stall && !halt_sys && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection, bus outputs and PC stall feedback.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = pc_addr;
        pc_hold   = halt_sys ? 1'b1 : (flush ? 1'b0 : !(do_accept || do_release));
        unique case (state_q)
            IDLE: begin
                if (!halt_sys) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack && flush) begin
                    state_d = REQ;
                end else if (flush) begin
                    state_d = DRAIN;
                end else if (imem_ack && (id_stall || halt_sys)) begin
                    state_d = HOLD;
                end else begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (flush || do_release) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Parking buffer and drain address; the drain address tracks the live request
    // so that a flush can keep the abandoned request stable until its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
            drain_addr_q <= '0;
        end else if (state_q == REQ) begin
            drain_addr_q <= pc_addr;
            if (imem_ack && !flush && (id_stall || halt_sys)) begin
                buf_instr_q <= imem_rdata;
                buf_pc_q    <= pc_addr;
            end
        end
    end

    assign ifid_load       = do_accept || do_release;
    assign ifid_load_instr = do_accept ? imem_rdata : buf_instr_q;
    assign ifid_load_pc    = do_accept ? pc_addr : buf_pc_q;

    reg_if_id #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_reg_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .stall      (id_stall),
        .load       (ifid_load),
        .load_instr (ifid_load_instr),
        .load_pc    (ifid_load_pc),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: models the PC register and instruction memory,
// expected deliveries are queued when the ack is driven and checked on IF/ID loads.
module tb_instr_fetch_unit;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_addr;
    logic        pc_hold;
    logic        halt_sys = 1'b0;
    logic        id_stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;

    logic [15:0] pc;
    logic [15:0] target = 16'h0000;
    logic [31:0] sb[$];
    int          total = 0;
    int          bad = 0;
    logic        cur_req;
    logic        cur_hold;
    logic [15:0] cur_addr;

    instr_fetch_unit #(
        .ADDR_W    (16),
        .INSTR_W   (16),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_addr    (pc_addr),
        .pc_hold    (pc_hold),
        .halt_sys   (halt_sys),
        .id_stall   (id_stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc)
    );

    always #5 clk = ~clk;

    // PC register: loads the redirect target on flush, else advances unless held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 16'h0000;
        else if (flush) pc <= target;
        else if (!pc_hold) pc <= pc + 16'd2;
    end
    assign pc_addr = pc;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // One clock: drive inputs at negedge, sample combinational outputs, then check IF/ID after the edge.
    task automatic cycle(input logic ack, input logic st, input logic fl, input logic hl);
        logic [31:0] exp;
        @(negedge clk);
        id_stall   = st;
        flush      = fl;
        halt_sys   = hl;
        imem_ack   = ack;
        imem_rdata = ack ? mem(imem_addr) : 16'hDEAD;
        #1;
        cur_req  = imem_req;
        cur_addr = imem_addr;
        cur_hold = pc_hold;
        @(posedge clk);
        #1;
        if (fl) begin
            total++;
            if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
                bad++;
                $display("FAIL flush_bubble: valid=%b instr=%h, required valid=0 instr=%h", ifid_valid, ifid_instr, NOP);
            end
        end else if (!st && ifid_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_delivery: instr=%h pc=%h, required no delivery", ifid_instr, ifid_pc);
            end else begin
                exp = sb.pop_front();
                if ({ifid_instr, ifid_pc} !== exp) begin
                    bad++;
                    $display("FAIL delivery: instr=%h pc=%h, required instr=%h pc=%h", ifid_instr, ifid_pc, exp[31:16], exp[15:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 16'h0000) begin
            bad++;
            $display("FAIL reset_ifid: valid=%b instr=%h pc=%h, required 0/%h/0000", ifid_valid, ifid_instr, ifid_pc, NOP);
        end
        total++;
        if (cur_req !== 1'b0 || cur_hold !== 1'b1) begin
            bad++;
            $display("FAIL reset_bus: req=%b hold=%b, required req=0 hold=1", cur_req, cur_hold);
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: req=%b, required 0", cur_req);
        end
    endtask

    task automatic zero_wait_run(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(2 * i);
            sb.push_back({mem(a), a});
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            total++;
            if (cur_req !== 1'b1 || cur_addr !== a || cur_hold !== 1'b0) begin
                bad++;
                $display("FAIL zero_wait: req=%b addr=%h hold=%b, required req=1 addr=%h hold=0", cur_req, cur_addr, cur_hold, a);
            end
        end
    endtask

    task automatic test_zero_wait();
        zero_wait_run(16'h0000, 8);
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (cur_req !== 1'b1 || cur_addr !== 16'h0010 || cur_hold !== 1'b1 || ifid_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_state: req=%b addr=%h hold=%b valid=%b, required 1/0010/1/0", cur_req, cur_addr, cur_hold, ifid_valid);
            end
        end
        sb.push_back({mem(16'h0010), 16'h0010});
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_addr !== 16'h0010 || cur_hold !== 1'b0) begin
            bad++;
            $display("FAIL wait_ack: addr=%h hold=%b, required addr=0010 hold=0", cur_addr, cur_hold);
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (ifid_valid !== 1'b1 || ifid_instr !== mem(16'h0010) || ifid_pc !== 16'h0010 || cur_hold !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: valid=%b instr=%h pc=%h hold=%b, required 1/%h/0010/1", ifid_valid, ifid_instr, ifid_pc, cur_hold, mem(16'h0010));
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (cur_req !== 1'b0 || cur_hold !== 1'b1) begin
            bad++;
            $display("FAIL stall_parked: req=%b hold=%b, required req=0 hold=1", cur_req, cur_hold);
        end
        sb.push_back({mem(16'h0012), 16'h0012});
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_hold !== 1'b0) begin
            bad++;
            $display("FAIL stall_release_hold: hold=%b, required 0", cur_hold);
        end
        zero_wait_run(16'h0014, 6);
    endtask

    task automatic test_flush_drain();
        target = 16'h0100;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (cur_addr !== 16'h0020 || cur_hold !== 1'b0) begin
            bad++;
            $display("FAIL flush_req: addr=%h hold=%b, required addr=0020 hold=0", cur_addr, cur_hold);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_req !== 1'b1 || cur_addr !== 16'h0020 || cur_hold !== 1'b1) begin
            bad++;
            $display("FAIL drain_addr: req=%b addr=%h hold=%b, required 1/0020/1", cur_req, cur_addr, cur_hold);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (cur_req !== 1'b1 || cur_addr !== 16'h0020) begin
            bad++;
            $display("FAIL drain_reflush: req=%b addr=%h, required 1/0020", cur_req, cur_addr);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_addr !== 16'h0020 || cur_hold !== 1'b1 || ifid_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_ack: addr=%h hold=%b valid=%b, required 0020/1/0", cur_addr, cur_hold, ifid_valid);
        end
        zero_wait_run(16'h0100, 1);
    endtask

    task automatic test_flush_ack();
        target = 16'h0200;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        zero_wait_run(16'h0200, 1);
        target = 16'h0300;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        zero_wait_run(16'h0300, 1);
    endtask

    task automatic test_halt();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (cur_req !== 1'b1 || cur_addr !== 16'h0302 || cur_hold !== 1'b1) begin
            bad++;
            $display("FAIL halt_req: req=%b addr=%h hold=%b, required 1/0302/1", cur_req, cur_addr, cur_hold);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (cur_hold !== 1'b1 || ifid_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_park: hold=%b valid=%b, required hold=1 valid=0", cur_hold, ifid_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            total++;
            if (cur_req !== 1'b0 || cur_hold !== 1'b1 || ifid_valid !== 1'b0) begin
                bad++;
                $display("FAIL halt_idle: req=%b hold=%b valid=%b, required 0/1/0", cur_req, cur_hold, ifid_valid);
            end
        end
        sb.push_back({mem(16'h0302), 16'h0302});
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_hold !== 1'b0) begin
            bad++;
            $display("FAIL halt_release: hold=%b, required 0", cur_hold);
        end
        zero_wait_run(16'h0304, 1);
    endtask

    task automatic test_reset_mid_drain();
        target = 16'h0400;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cur_req !== 1'b1 || cur_addr !== 16'h0306) begin
            bad++;
            $display("FAIL pre_reset_drain: req=%b addr=%h, required 1/0306", cur_req, cur_addr);
        end
        @(negedge clk);
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 16'h0000 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%b instr=%h pc=%h req=%b, required 0/%h/0000/0", ifid_valid, ifid_instr, ifid_pc, imem_req, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush_drain();
        test_flush_ack();
        test_halt();
        test_reset_mid_drain();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL undelivered: pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
